// File: rtl/ram_bit_writer_if.sv
// Serial-source / RAM-write bundle for the bit-serial RAM writer.
// master = stream source and observer, slave = packer.
interface ram_bit_writer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 11
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic                  bit_in;
   logic                  bit_valid;
   logic                  bit_ready;
   logic                  flush;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  busy;
   logic                  full;
   logic [ADDR_WIDTH:0]   byte_count;

   modport master (
      output start, base_addr, bit_in, bit_valid, flush,
      input  bit_ready, we, addr_out, data_out, busy, full, byte_count
   );

   modport slave (
      input  start, base_addr, bit_in, bit_valid, flush,
      output bit_ready, we, addr_out, data_out, busy, full, byte_count
   );
endinterface

// File: rtl/ram_bit_writer.sv
// Packs a serial bit stream into DATA_WIDTH words and writes them to RAM at auto-incrementing addresses.
// Latency: we pulses the cycle after the word's last bit is accepted; DATA_WIDTH+1 cycles per word at best.
// Backpressure: bit_ready low outside SHIFT (write cycle, idle, full); the source holds its bit until accepted.
module ram_bit_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 11,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   ram_bit_writer_if.slave  bus
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] WORD_BITS = CW'(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WRITE, S_FULL} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] shifted;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH:0]   bcnt_q, bcnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         shreg_q <= '0;
         cnt_q   <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      if (MSB_FIRST)
         shifted = {shreg_q[DATA_WIDTH-2:0], bus.bit_in};
      else
         shifted = {bus.bit_in, shreg_q[DATA_WIDTH-1:1]};

      if (bus.start) begin
         addr_d  = bus.base_addr;
         bcnt_d  = '0;
         cnt_d   = '0;
         shreg_d = '0;
         state_d = S_SHIFT;
      end else begin
         case (state_q)
            S_SHIFT: begin
               if (bus.bit_valid) begin
                  shreg_d = shifted;
                  cnt_d   = cnt_q + 1'b1;
               end
               // A bit arriving with flush is absorbed first; a completed word wins over flush
               if (cnt_d == WORD_BITS) begin
                  data_d  = shreg_d;
                  state_d = S_WRITE;
               end else if (bus.flush && cnt_d != '0) begin
                  if (MSB_FIRST)
                     data_d = shreg_d << (WORD_BITS - cnt_d);
                  else
                     data_d = shreg_d >> (WORD_BITS - cnt_d);
                  state_d = S_WRITE;
               end
            end
            S_WRITE: begin
               bcnt_d  = bcnt_q + 1'b1;
               cnt_d   = '0;
               shreg_d = '0;
               if (&addr_q) begin
                  state_d = S_FULL;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = S_SHIFT;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.bit_ready  = (state_q == S_SHIFT);
   assign bus.we         = (state_q == S_WRITE);
   assign bus.busy       = (state_q == S_SHIFT) || (state_q == S_WRITE);
   assign bus.full       = (state_q == S_FULL);
   assign bus.addr_out   = addr_q;
   assign bus.data_out   = data_q;
   assign bus.byte_count = bcnt_q;
endmodule

// File: tb/tb_ram_bit_writer.sv
// Directed and randomized bench for ram_bit_writer; expected words come from a queue of accepted bits.
module tb_ram_bit_writer;
   localparam int DW = 8;
   localparam int AW = 11;
   localparam bit MSB = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_bit_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

   ram_bit_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MSB_FIRST(MSB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int wa_q[$];
   int wd_q[$];
   bit cur[$];

   always @(negedge clk) begin
      if (bif.we === 1'b1) begin
         wa_q.push_back(int'(bif.addr_out));
         wd_q.push_back(int'(bif.data_out));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word the model expects from the bits accepted so far, zero-filled.
   function automatic logic [31:0] pack();
      logic [DW-1:0] w = '0;
      foreach (cur[i]) begin
         if (MSB) w[DW-1-i] = cur[i];
         else     w[i]      = cur[i];
      end
      return 32'(w);
   endfunction

   task automatic send_bit(input bit b, input int budget, output bit ok);
      int n = 0;
      bif.bit_in    = b;
      bif.bit_valid = 1'b1;
      while (bif.bit_ready !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      ok = (bif.bit_ready === 1'b1);
      if (ok) begin
         tick();
         cur.push_back(b);
      end
   endtask

   task automatic send(input bit b);
      bit ok;
      send_bit(b, 50, ok);
      check("bit_accept", 32'(ok), 32'd1);
   endtask

   task automatic send_byte(input logic [DW-1:0] v);
      for (int i = DW - 1; i >= 0; i--) send(v[i]);
      bif.bit_valid = 1'b0;
   endtask

   task automatic do_start(input int base);
      bif.base_addr = AW'(base);
      bif.start     = 1'b1;
      tick();
      bif.start = 1'b0;
      cur.delete();
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_flags"}, {28'd0, bif.we, bif.bit_ready, bif.busy, bif.full}, 32'd0);
      check({tag, "_addr"}, 32'(bif.addr_out), 32'd0);
      check({tag, "_data"}, 32'(bif.data_out), 32'd0);
      check({tag, "_bcnt"}, 32'(bif.byte_count), 32'd0);
   endtask

   initial begin
      logic [31:0] exp_a, exp_b;
      int rdy_cnt, we_cnt, base, nb, k;
      int ed[$];
      bit ok;
      logic [DW-1:0] v;

      bif.start = 0; bif.base_addr = '0; bif.bit_in = 0; bif.bit_valid = 0; bif.flush = 0;
      #3;
      check_all_zero("reset");
      tick();
      rst = 1'b0;

      // Idle without start: nothing accepted, nothing written
      bif.bit_valid = 1'b1;
      rdy_cnt = 0; we_cnt = 0;
      repeat (20) begin
         tick();
         rdy_cnt += int'(bif.bit_ready);
         we_cnt  += int'(bif.we);
      end
      bif.bit_valid = 1'b0;
      check("idle_ready", 32'(rdy_cnt), 32'd0);
      check("idle_we", 32'(we_cnt), 32'd0);

      // Basic continuous pack
      do_start(0);
      send_byte(8'hA5);
      exp_a = pack();
      cur.delete();
      check("basic_we_timing", 32'(bif.we), 32'd1);
      check("basic_ready_in_write", 32'(bif.bit_ready), 32'd0);
      check("basic_addr0", 32'(bif.addr_out), 32'd0);
      check("basic_data0", 32'(bif.data_out), exp_a);
      tick();
      check("basic_ready_after", 32'(bif.bit_ready), 32'd1);
      check("basic_we_single", 32'(bif.we), 32'd0);
      send_byte(8'h3C);
      exp_b = pack();
      cur.delete();
      tick();
      check("basic_bcnt", 32'(bif.byte_count), 32'd2);
      check("basic_nwr", 32'(wa_q.size()), 32'd2);
      if (wa_q.size() == 2) begin
         check("basic_wr_addr1", 32'(wa_q[1]), 32'd1);
         check("basic_wr_data1", 32'(wd_q[1]), exp_b);
      end

      // Gapped source
      do_start(5);
      v = 8'hA5;
      for (int i = DW - 1; i >= 0; i--) begin
         send(v[i]);
         bif.bit_valid = 1'b0;
         if (i > 0) begin
            tick();
            check("gap_no_write", 32'(wa_q.size()), 32'd0);
         end
      end
      exp_a = pack();
      cur.delete();
      tick();
      check("gap_nwr", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() == 1) begin
         check("gap_addr", 32'(wa_q[0]), 32'd5);
         check("gap_data", 32'(wd_q[0]), exp_a);
      end

      // Flush with 3 bits, then with none, then coincident with the final bit
      do_start(10);
      send(1'b1); send(1'b1); send(1'b0);
      bif.bit_valid = 1'b0;
      exp_a = pack();
      cur.delete();
      bif.flush = 1'b1;
      tick();
      bif.flush = 1'b0;
      check("flush_we", 32'(bif.we), 32'd1);
      check("flush_data", 32'(bif.data_out), exp_a);
      check("flush_addr", 32'(bif.addr_out), 32'd10);
      tick();
      bif.flush = 1'b1;
      tick();
      bif.flush = 1'b0;
      repeat (3) tick();
      check("flush_empty_nwr", 32'(wa_q.size()), 32'd1);
      v = 8'h96;
      for (int i = DW - 1; i >= 1; i--) send(v[i]);
      bif.bit_in = v[0]; bif.bit_valid = 1'b1; bif.flush = 1'b1;
      tick();
      cur.push_back(v[0]);
      bif.flush = 1'b0; bif.bit_valid = 1'b0;
      exp_b = pack();
      cur.delete();
      repeat (4) tick();
      check("flush_coinc_nwr", 32'(wa_q.size()), 32'd2);
      if (wa_q.size() == 2) begin
         check("flush_coinc_addr", 32'(wa_q[1]), 32'd11);
         check("flush_coinc_data", 32'(wd_q[1]), exp_b);
      end

      // Random bytes with random gaps, ending in a flushed partial word
      base = $urandom_range(0, 1500);
      do_start(base);
      nb = $urandom_range(3, 6);
      ed.delete();
      for (int j = 0; j < nb; j++) begin
         for (int i = 0; i < DW; i++) begin
            bif.bit_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            send(1'($urandom));
         end
         bif.bit_valid = 1'b0;
         ed.push_back(int'(pack()));
         cur.delete();
      end
      k = $urandom_range(1, DW - 1);
      for (int i = 0; i < k; i++) send(1'($urandom));
      bif.bit_valid = 1'b0;
      ed.push_back(int'(pack()));
      cur.delete();
      bif.flush = 1'b1;
      tick();
      bif.flush = 1'b0;
      repeat (3) tick();
      check("rand_nwr", 32'(wa_q.size()), 32'(nb + 1));
      check("rand_bcnt", 32'(bif.byte_count), 32'(nb + 1));
      for (int j = 0; j < wa_q.size() && j < ed.size(); j++) begin
         check("rand_addr", 32'(wa_q[j]), 32'(base + j));
         check("rand_data", 32'(wd_q[j]), 32'(ed[j]));
      end

      // Fill to the top of the address space
      do_start(2046);
      send_byte(8'($urandom));
      exp_a = pack(); cur.delete();
      send_byte(8'($urandom));
      exp_b = pack(); cur.delete();
      tick();
      check("full_flag", 32'(bif.full), 32'd1);
      check("full_ready", 32'(bif.bit_ready), 32'd0);
      check("full_busy", 32'(bif.busy), 32'd0);
      check("full_bcnt", 32'(bif.byte_count), 32'd2);
      send_bit(1'b1, 20, ok);
      bif.bit_valid = 1'b0;
      cur.delete();
      check("full_no_accept", 32'(ok), 32'd0);
      check("full_addr_hold", 32'(bif.addr_out), 32'd2047);
      check("full_nwr", 32'(wa_q.size()), 32'd2);
      if (wa_q.size() == 2) begin
         check("full_addr0", 32'(wa_q[0]), 32'd2046);
         check("full_data0", 32'(wd_q[0]), exp_a);
         check("full_addr1", 32'(wa_q[1]), 32'd2047);
         check("full_data1", 32'(wd_q[1]), exp_b);
      end

      // Restart mid-word: start coincides with the fifth bit
      do_start(300);
      for (int i = 0; i < 4; i++) send(1'($urandom));
      bif.bit_in = 1'b1; bif.bit_valid = 1'b1;
      bif.base_addr = AW'(100); bif.start = 1'b1;
      tick();
      bif.start = 1'b0; bif.bit_valid = 1'b0;
      cur.delete();
      tick();
      check("restart_no_write", 32'(wa_q.size()), 32'd0);
      check("restart_bcnt0", 32'(bif.byte_count), 32'd0);
      send_byte(8'($urandom));
      exp_a = pack(); cur.delete();
      tick();
      check("restart_nwr", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() == 1) begin
         check("restart_addr", 32'(wa_q[0]), 32'd100);
         check("restart_data", 32'(wd_q[0]), exp_a);
      end
      check("restart_bcnt1", 32'(bif.byte_count), 32'd1);

      // Start during the write cycle aborts it
      send_byte(8'($urandom));
      cur.delete();
      check("abort_we_before", 32'(bif.we), 32'd1);
      bif.base_addr = AW'(200); bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      check("abort_we_after", 32'(bif.we), 32'd0);
      check("abort_addr", 32'(bif.addr_out), 32'd200);
      check("abort_bcnt", 32'(bif.byte_count), 32'd0);
      check("abort_busy", 32'(bif.busy), 32'd1);

      // Asynchronous reset in the middle of a write
      send_byte(8'($urandom));
      cur.delete();
      check("rstw_we_before", 32'(bif.we), 32'd1);
      #2 rst = 1'b1;
      #1 check_all_zero("rst_midwrite");
      tick();
      rst = 1'b0;
      tick();
      check("rst_stays_idle", 32'(bif.bit_ready), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_bit_writer.md
Name: ram_bit_writer

Overview:
- Bit-serial to byte packer that fills the DATA_WIDTH x 2^ADDR_WIDTH single-port RAM from a serial bit stream.
- It is the write-side counterpart of the bit-serial RAM read path.
- Drives the RAM write interface (we, address, data) directly, with auto-incrementing address from a programmable base.
- Sits between a serial source (UART/shift front-end) and the RAM.

Parameters:
DATA_WIDTH, 8, bits per RAM word / bits packed per write
ADDR_WIDTH, 11, RAM address width (2048 words)
MSB_FIRST, 1, 1: first received bit lands in data_out[DATA_WIDTH-1]; 0: lands in data_out[0]

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse: load base_addr, clear counters, begin packing
base_addr  input  ADDR_WIDTH  first RAM address to write, sampled on start
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in valid this cycle
bit_ready  output  1  block accepts a bit this cycle (transfer = bit_valid & bit_ready)
flush  input  1  single-cycle pulse: zero-pad and write any partial word
we  output  1  RAM write enable, one-cycle pulse per word
addr_out  output  ADDR_WIDTH  RAM write address
data_out  output  DATA_WIDTH  RAM write data
busy  output  1  high in SHIFT or WRITE
full  output  1  last address written, no further writes
byte_count  output  ADDR_WIDTH+1  words written since last start

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0 (bit_ready, we, addr_out, data_out, busy, full, byte_count); shift register and bit counter cleared.
- FSM states: IDLE, SHIFT, WRITE, FULL.
- IDLE: bit_ready=0. On start: addr_out<=base_addr, byte_count<=0, bit counter<=0, shift reg<=0, go to SHIFT.
- SHIFT: bit_ready=1, busy=1.
  - Each transfer shifts bit_in into the register per MSB_FIRST and increments the bit counter.
  - The transfer that brings the count to DATA_WIDTH latches the word into data_out and goes to WRITE.
- WRITE: we=1 for exactly one cycle; bit_ready=0; addr_out and data_out stable for the whole cycle.
  - At the end of WRITE: byte_count+1, bit counter<=0.
  - If addr_out == 2^ADDR_WIDTH-1: go to FULL, addr_out holds (no wrap).
  - Otherwise addr_out+1 and return to SHIFT.
- Timing:
  - Last bit accepted at edge N gives we=1 in the cycle after edge N, and bit_ready=1 again after edge N+1.
  - Peak throughput is DATA_WIDTH+1 cycles per word.
- Flush:
  - In SHIFT with bit counter>0: remaining bit positions are zero-filled (received bits keep their MSB_FIRST placement), then go to WRITE.
  - With bit counter=0, or in any other state: ignored.
  - Same cycle as a transfer: the bit is accepted first, then flush applies. If that bit completes the word, a single normal write occurs and there is no extra empty write.
- FULL: full=1, bit_ready=0, busy=0. Held until start or rst. data_out/addr_out keep the last written values.
- Start in any state, including mid-word and in WRITE (the write cycle is aborted, we deasserts):
  - Discards the partial word, reloads base_addr, clears byte_count and full, enters SHIFT.
  - start has priority over flush and bit transfers in the same cycle.
- bit_valid while bit_ready=0: no transfer, no state change; the source must hold the bit.
- Asynchronous reset mid-word or mid-write: we drops immediately and the partial word is lost.
- byte_count saturates naturally at 2^ADDR_WIDTH (reached only when base_addr=0 and the RAM is filled).

Test Plan:
- Reset/idle: assert rst mid-operation → all outputs 0 within the same cycle; with no start pulse, bit_valid=1 for 20 cycles → bit_ready=0 and no we.
- Basic pack: start with base_addr=0, stream bits 1,0,1,0,0,1,0,1 continuously → one we pulse with addr_out=0 and data_out=8'hA5; next word 8'h3C → we with addr_out=1; byte_count=2.
- Gapped source: same byte with bit_valid toggling every other cycle → identical 8'hA5 write; we only after the 8th accepted bit; no writes during gaps.
- Flush: after 3 bits 1,1,0, pulse flush → we with data_out=8'hC0 (MSB_FIRST=1) or 8'h03 (MSB_FIRST=0). Flush with 0 bits pending → no we. Flush coincident with the 8th bit → exactly one we.
- Full: start with base_addr=2046, send 3 bytes → writes at 2046 and 2047, then full=1 and bit_ready=0; the third byte is not accepted; no wrap to 0; byte_count=2.
- Restart: start during bit 5 of a word with base_addr=100 → no write of the partial word; next full byte is written at addr 100 with byte_count=1; start during the WRITE cycle → we deasserts the next cycle.
